muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit that sits directly downstream of the ALU function decoder.
- Consumes the 5-bit ALU function code (ALU_MUL … ALU_REMU) plus both operands, and returns a 32-bit result over a valid/ready handshake.
- Used by multicycle/pipelined cores when M_MODULE is defined; the core stalls on busy.

Parameters:
- XLEN, 32, operand/result width; the counter is $clog2(XLEN)+1 bits wide.

Ports:
- clock  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort of any in-flight operation
- in_valid  in  1  request present
- in_ready  out  1  unit can accept (high only in IDLE)
- in_function  in  5  ALU function code from the shared constants
- in_operand_a  in  XLEN  rs1 value (multiplicand / dividend)
- in_operand_b  in  XLEN  rs2 value (multiplier / divisor)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_result  out  XLEN  result
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, low): state=IDLE, out_valid=0, out_result=0, busy=0, in_ready=1, all internal registers 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE: accept when in_valid && in_ready && !flush.
  - Latch function, signedness flags and operand magnitudes (two's-complement abs for signed operands).
  - Clear the 64-bit accumulator and load counter=XLEN.
  - Move to CALC, except for the early-exit cases below, which go straight to DONE.
- Signedness:
  - MULH, DIV, REM: a signed, b signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - MUL: treated as unsigned; the low word is identical either way.
- CALC, multiply: radix-2 shift-add, one multiplier bit per cycle, LSB first, producing the 64-bit unsigned product.
- CALC, divide: restoring division, one quotient bit per cycle, MSB first, producing the unsigned quotient/remainder.
- CALC ends: decrement counter each cycle; go to FIX when counter reaches 1 on the current edge.
- FIX (1 cycle) applies sign correction and selects the result:
  - Product is negated if sign(a) != sign(b) among the signed operands.
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
  - Quotient is negated if signed and the signs differ; remainder takes the sign of the dividend.
  - Result is registered into out_result; state goes to DONE.
- DONE: out_valid=1 and out_result held stable until out_ready. On the handshake edge: out_valid=0, state goes to IDLE. There is no same-cycle re-accept.
- Latency: out_valid rises exactly XLEN+1 cycles after the accept edge (33 for XLEN=32), with no data dependence.
- Early exits (out_valid rises the cycle after accept):
  - Divisor 0: DIV/DIVU return all ones; REM/REMU return the dividend.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
  - Any non-M function code returns 0.
- flush:
  - In any state, the next state is IDLE and out_valid drops on the next edge. No result is delivered and the latched operands are discarded.
  - flush with in_valid in IDLE: no accept (flush wins).
- Reset asserted mid-operation: outputs go to their reset values immediately; no partial result is ever presented.
- Once out_valid is high, out_result never changes until the handshake or a flush.

Decomposition:
- ALU_MUL…ALU_REMU codes, M-function funct3 values and the XLEN default stay in the shared constants/config includes.
- Add a shared muldiv_state_t enum (IDLE/CALC/FIX/DONE) there.
- One natural sub-module: muldiv_step, the combinational single-iteration datapath (shift-add step and restoring-subtract step) selected by an is_div bit. The FSM, counter and sign handling stay in muldiv_unit.

Test Plan:
- MUL a=7, b=0xFFFFFFFD → out_result 0xFFFFFFEB; out_valid exactly 33 cycles after accept; busy=1 throughout.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- Signed and unsigned divide:
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9/2 → 0xFFFFFFFF.
  - DIVU 7/2 → 3.
  - REMU 0xFFFFFFF9/2 → 1.
- Early-exit cases, each with out_valid one cycle after accept:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid and out_result stable, in_ready=0. Raise out_ready → IDLE next cycle, and a new in_valid is accepted the cycle after.
- Abort paths:
  - flush on the 10th CALC cycle → IDLE next cycle; out_valid never rises; the following MUL 3×4 returns 12.
  - reset driven low mid-CALC → out_valid=0 and busy=0 asynchronously.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the M-extension execution unit: function codes,
// funct3 encodings, default width and the sequencer state type.
package muldiv_unit_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // M functions occupy one aligned block of the ALU code space; low bits are funct3.
    localparam logic [1:0] ALU_M_GROUP = 2'b10;

    localparam logic [4:0] ALU_MUL    = {ALU_M_GROUP, F3_MUL};
    localparam logic [4:0] ALU_MULH   = {ALU_M_GROUP, F3_MULH};
    localparam logic [4:0] ALU_MULHSU = {ALU_M_GROUP, F3_MULHSU};
    localparam logic [4:0] ALU_MULHU  = {ALU_M_GROUP, F3_MULHU};
    localparam logic [4:0] ALU_DIV    = {ALU_M_GROUP, F3_DIV};
    localparam logic [4:0] ALU_DIVU   = {ALU_M_GROUP, F3_DIVU};
    localparam logic [4:0] ALU_REM    = {ALU_M_GROUP, F3_REM};
    localparam logic [4:0] ALU_REMU   = {ALU_M_GROUP, F3_REMU};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    function automatic logic is_m_fn(input logic [4:0] fn);
        return fn[4:3] == ALU_M_GROUP;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply step (LSB first)
// or restoring divide step (MSB first), selected by is_div.
module muldiv_step
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opa_i,
    input  logic [XLEN-1:0]   opb_i,
    output logic [2*XLEN-1:0] acc_o,
    output logic [XLEN-1:0]   opa_o,
    output logic [XLEN-1:0]   opb_o
);

    logic [XLEN-1:0] addend;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] diff;
    logic            fits;

    always_comb begin
        addend = opb_i[0] ? opa_i : '0;
        sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, addend};

        // Partial remainder is always below the divisor, so the difference fits XLEN bits.
        rem_sh = {acc_i[2*XLEN-1:XLEN], opa_i[XLEN-1]};
        fits   = rem_sh >= {1'b0, opb_i};
        diff   = rem_sh[XLEN-1:0] - opb_i;

        if (is_div) begin
            acc_o = {(fits ? diff : rem_sh[XLEN-1:0]), acc_i[XLEN-2:0], fits};
            opa_o = {opa_i[XLEN-2:0], 1'b0};
            opb_o = opb_i;
        end else begin
            acc_o = {sum, acc_i[XLEN-1:1]};
            opa_o = opa_i;
            opb_o = {1'b0, opb_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitudes in, XLEN unsigned steps,
// one sign-fix cycle, result held over a valid/ready handshake.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | one multiply/divide step per cycle, counter XLEN..1
// FIX   | apply sign correction and select the result word
// DONE  | out_valid high, result held until out_ready
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_function,
    input  logic [XLEN-1:0] in_operand_a,
    input  logic [XLEN-1:0] in_operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN) + 1;

    muldiv_state_t     state_q, state_d;
    logic [2:0]        func_q, func_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_result_q, out_result_d;

    logic [2*XLEN-1:0] acc_s;
    logic [XLEN-1:0]   opa_s, opb_s;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div (func_q[2]),
        .acc_i  (acc_q),
        .opa_i  (opa_q),
        .opb_i  (opb_q),
        .acc_o  (acc_s),
        .opa_o  (opa_s),
        .opb_o  (opb_s)
    );

    logic            sgn_a, sgn_b, in_neg_a, in_neg_b;
    logic            in_is_m, in_is_div, b_zero, ovf, early;
    logic [XLEN-1:0] a_mag, b_mag, early_res;

    always_comb begin
        sgn_a     = in_function inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
        sgn_b     = in_function inside {ALU_MULH, ALU_DIV, ALU_REM};
        in_neg_a  = sgn_a & in_operand_a[XLEN-1];
        in_neg_b  = sgn_b & in_operand_b[XLEN-1];
        a_mag     = in_neg_a ? -in_operand_a : in_operand_a;
        b_mag     = in_neg_b ? -in_operand_b : in_operand_b;
        in_is_m   = is_m_fn(in_function);
        in_is_div = in_function[2];
        b_zero    = in_operand_b == '0;
        ovf       = sgn_b && in_is_div && (in_operand_b == '1)
                    && (in_operand_a == {1'b1, {(XLEN-1){1'b0}}});
        early     = !in_is_m || (in_is_div && (b_zero || ovf));

        // Cases whose answer is fixed by the ISA rather than by iteration.
        early_res = '0;
        if (in_is_m && in_is_div) begin
            if (b_zero)
                early_res = in_function[1] ? in_operand_a : '1;
            else if (ovf)
                early_res = in_function[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    always_comb begin
        prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quo  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (!func_q[2])
            fix_res = (func_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else
            fix_res = func_q[1] ? rem : quo;
    end

    always_comb begin
        state_d      = state_q;
        func_d       = func_q;
        neg_a_d      = neg_a_q;
        neg_b_d      = neg_b_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;

        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    func_d  = in_function[2:0];
                    neg_a_d = in_neg_a;
                    neg_b_d = in_neg_b;
                    opa_d   = a_mag;
                    opb_d   = b_mag;
                    acc_d   = '0;
                    cnt_d   = CW'(XLEN);
                    if (early) begin
                        state_d      = DONE;
                        out_valid_d  = 1'b1;
                        out_result_d = early_res;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = acc_s;
                opa_d = opa_s;
                opb_d = opb_s;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = FIX;
            end
            FIX: begin
                out_result_d = fix_res;
                out_valid_d  = 1'b1;
                state_d      = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            opa_d       = '0;
            opb_d       = '0;
            acc_d       = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            func_q       <= '0;
            neg_a_q      <= 1'b0;
            neg_b_q      <= 1'b0;
            opa_q        <= '0;
            opb_q        <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else begin
            state_q      <= state_d;
            func_q       <= func_d;
            neg_a_q      <= neg_a_d;
            neg_b_q      <= neg_b_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors push expected results,
// a negedge monitor pops and compares on every result handshake.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 1;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [4:0]      in_function = '0;
    logic [XLEN-1:0] in_operand_a = '0;
    logic [XLEN-1:0] in_operand_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] out_result;
    logic            busy;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_function  (in_function),
        .in_operand_a (in_operand_a),
        .in_operand_b (in_operand_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    int              n_vec = 0;
    int              n_err = 0;
    logic [XLEN-1:0] exp_q[$];
    string           name_q[$];
    logic [XLEN-1:0] mon_exp;
    string           mon_name;

    task automatic check(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got %h, required no result pending", out_result);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                check(mon_name, out_result, mon_exp);
            end
        end
    end

    // Caller is positioned just after a rising edge with the unit in IDLE.
    task automatic start_op(input logic [4:0] fn, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [XLEN-1:0] exp, input string nm, input bit push);
        in_function  = fn;
        in_operand_a = a;
        in_operand_b = b;
        in_valid     = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        if (push) begin
            exp_q.push_back(exp);
            name_q.push_back(nm);
        end
        check({nm, "_accepted"}, {31'b0, in_ready}, 32'd0);
    endtask

    task automatic wait_valid(input int exp_lat, input string nm);
        int lat = 0;
        bit busy_ok = 1'b1;
        while (!out_valid && lat < 200) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clock);
            #1;
            lat++;
        end
        check({nm, "_latency"}, lat, exp_lat);
        check({nm, "_busy"}, {31'b0, busy_ok}, 32'd1);
    endtask

    task automatic finish_op(input string nm);
        int t = 0;
        while (out_valid && t < 50) begin
            @(posedge clock);
            #1;
            t++;
        end
        check({nm, "_released"}, {31'b0, out_valid}, 32'd0);
    endtask

    task automatic run_op(input logic [4:0] fn, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] exp, input int lat, input string nm);
        start_op(fn, a, b, exp, nm, 1'b1);
        wait_valid(lat, nm);
        finish_op(nm);
    endtask

    initial begin
        bit seen;
        #1 reset = 1'b0;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;

        run_op(ALU_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT, "mul_7_m3");
        run_op(ALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT, "mulh_min_min");
        run_op(ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT, "mulhu_max");
        run_op(ALU_MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, LAT, "mulhsu_m1_2");
        run_op(ALU_MULH,   32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, LAT, "mulh_m3_5");
        run_op(ALU_MUL,    32'h0001_0001, 32'h0001_0001, 32'h0002_0001, LAT, "mul_wrap");
        run_op(ALU_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, LAT, "div_m7_2");
        run_op(ALU_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, LAT, "rem_m7_2");
        run_op(ALU_DIVU,   32'd7,        32'd2,        32'd3,        LAT, "divu_7_2");
        run_op(ALU_REMU,   32'hFFFF_FFF9, 32'd2,        32'd1,        LAT, "remu_big_2");
        run_op(ALU_DIV,    32'd100,      32'hFFFF_FFF9, 32'hFFFF_FFF2, LAT, "div_100_m7");
        run_op(ALU_REM,    32'd100,      32'hFFFF_FFF9, 32'd2,        LAT, "rem_100_m7");
        run_op(ALU_DIVU,   32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, LAT, "divu_max_1");

        // Early exits: result is registered on the accept edge itself.
        run_op(ALU_DIV,    32'd5,        32'd0,        32'hFFFF_FFFF, 0, "div_by_zero");
        run_op(ALU_DIVU,   32'd5,        32'd0,        32'hFFFF_FFFF, 0, "divu_by_zero");
        run_op(ALU_REMU,   32'd5,        32'd0,        32'd5,        0, "remu_by_zero");
        run_op(ALU_REM,    32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 0, "rem_by_zero");
        run_op(ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "div_ovf");
        run_op(ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        0, "rem_ovf");
        run_op(5'd3,       32'd9,        32'd9,        32'd0,        0, "non_m_code");

        out_ready = 1'b0;
        start_op(ALU_MUL, 32'd6, 32'd7, 32'd42, "bp_mul", 1'b1);
        wait_valid(LAT, "bp_mul");
        repeat (5) begin
            @(posedge clock);
            #1;
            check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            check("bp_hold_result", out_result, 32'd42);
            check("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("bp_release_valid", {31'b0, out_valid}, 32'd0);
        check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        start_op(ALU_DIVU, 32'd9, 32'd4, 32'd2, "bp_next", 1'b1);
        wait_valid(LAT, "bp_next");
        finish_op("bp_next");

        start_op(ALU_MUL, 32'h1234_5678, 32'd3, 32'd0, "fl_start", 1'b0);
        repeat (9) @(posedge clock);
        #1 flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        check("fl_busy", {31'b0, busy}, 32'd0);
        check("fl_in_ready", {31'b0, in_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("fl_no_result", {31'b0, seen}, 32'd0);
        run_op(ALU_MUL, 32'd3, 32'd4, 32'd12, LAT, "fl_mul_3_4");

        flush        = 1'b1;
        in_valid     = 1'b1;
        in_function  = ALU_MUL;
        in_operand_a = 32'd2;
        in_operand_b = 32'd2;
        @(posedge clock);
        #1;
        check("fl_idle_no_accept", {31'b0, busy}, 32'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        @(posedge clock);
        #1;

        start_op(ALU_MUL, 32'd5, 32'd5, 32'd0, "rst_start", 1'b0);
        repeat (5) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_valid", {31'b0, out_valid}, 32'd0);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_result", out_result, 32'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
        run_op(ALU_DIVU, 32'd100, 32'd7, 32'd14, LAT, "post_rst_divu");

        check("sb_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
